iter_divider: RTL and testbench

- Multi-cycle iterative restoring divider; the inverse counterpart to the single-cycle ALU multiply path.
- Executes div/divu for the datapath: quotient goes to LO, remainder to HI.
- Sits beside the ALU and uses a start/busy/done handshake, so the control unit stalls the pipeline while busy=1.

---
 rtl/iter_divider.sv | 211 +++++++++++++++++++++
 tb/tb_iter_divider.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
`default_nettype none
// ============================================================================
// Module   : iter_divider
// Purpose  : Multi-cycle iterative restoring divider for div/divu. Quotient is
//            destined for LO, remainder for HI. A start/busy/done handshake
//            lets the control unit stall the pipeline while busy is high.
// Ports    : clk         - system clock, rising edge
//            rst_n       - asynchronous active-low reset
//            start       - division request, sampled only while idle
//            sign        - 1 = signed (div), 0 = unsigned (divu)
//            dividend    - A operand, latched on accepted start
//            divisor     - B operand, latched on accepted start
//            busy        - high from the cycle after accept until done
//            done        - one-cycle pulse, results valid
//            quotient    - registered quotient, held until next done
//            remainder   - registered remainder, held until next done
//            div_by_zero - (ITER_DIVIDER_DBZ_FLAG_EN only) latched divisor was
//                          zero, registered with the results
// Options  : define ITER_DIVIDER_DBZ_FLAG_EN to add the div_by_zero output.
// Latency  : done is visible WIDTH+1 cycles after the accepting edge.
// Revision : 1.0 - initial release
// ============================================================================
module iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
`ifdef ITER_DIVIDER_DBZ_FLAG_EN
    ,
    output logic             div_by_zero
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] C_ONE       = WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;       // partial remainder (magnitude)
    logic [WIDTH-1:0] quo_q, quo_d;       // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_q, dvs_d;       // divisor magnitude
    logic [WIDTH-1:0] dvd_q, dvd_d;       // original dividend, returned on divide by zero
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;

    // Operand magnitudes. Negating on WIDTH bits and reading the result as
    // unsigned maps -2^(WIDTH-1) to +2^(WIDTH-1), so the most negative value
    // needs no extra bit.
    logic             w_dvd_neg, w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag, w_dvs_mag;

    // One restoring step.
    logic [WIDTH:0]   w_shifted;
    logic             w_fits;
    logic [WIDTH-1:0] w_trial;

    always_comb begin
        w_dvd_neg = sign & dividend[WIDTH-1];
        w_dvs_neg = sign & divisor[WIDTH-1];
        w_dvd_mag = w_dvd_neg ? (~dividend + C_ONE) : dividend;
        w_dvs_mag = w_dvs_neg ? (~divisor + C_ONE) : divisor;

        w_shifted = {rem_q, quo_q[WIDTH-1]};
        w_fits    = (w_shifted >= {1'b0, dvs_q});
        // When the trial fits the true difference is below the divisor, so
        // the low WIDTH bits are exact.
        w_trial   = w_shifted[WIDTH-1:0] - dvs_q;
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        dvd_d       = dvd_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        dbz_d       = dbz_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    rem_d     = '0;
                    quo_d     = w_dvd_mag;
                    dvs_d     = w_dvs_mag;
                    dvd_d     = dividend;
                    neg_quo_d = w_dvd_neg ^ w_dvs_neg;
                    neg_rem_d = w_dvd_neg;
                    dbz_d     = (divisor == '0);
                    count_d   = '0;
                    busy_d    = 1'b1;
                    state_d   = S_CALC;
                end
            end

            S_CALC: begin
                rem_d   = w_fits ? w_trial : w_shifted[WIDTH-1:0];
                quo_d   = {quo_q[WIDTH-2:0], w_fits};
                count_d = count_q + CNT_W'(1);
                if (count_q == C_LAST_STEP) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                // Divide by zero bypasses sign correction entirely; the
                // iteration result is discarded.
                if (dbz_q) begin
                    quotient_d  = '1;
                    remainder_d = dvd_q;
                end else begin
                    quotient_d  = neg_quo_q ? (~quo_q + C_ONE) : quo_q;
                    remainder_d = neg_rem_q ? (~rem_q + C_ONE) : rem_q;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            dvd_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            dvd_q       <= dvd_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            dbz_q       <= dbz_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

`ifdef ITER_DIVIDER_DBZ_FLAG_EN
    logic dbz_flag_q, dbz_flag_d;

    always_comb begin
        dbz_flag_d = dbz_flag_q;
        if (state_q == S_FIX) begin
            dbz_flag_d = dbz_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbz_flag_q <= 1'b0;
        end else begin
            dbz_flag_q <= dbz_flag_d;
        end
    end

    assign div_by_zero = dbz_flag_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_iter_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_iter_divider
// Purpose  : Directed self-checking bench for iter_divider (WIDTH=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_iter_divider;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 1;
    localparam int BOUND = 80;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             sign;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
`ifdef ITER_DIVIDER_DBZ_FLAG_EN
    logic             div_by_zero;
`endif

    int n_checks = 0;
    int n_errors = 0;

    iter_divider #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .sign       (sign),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder)
`ifdef ITER_DIVIDER_DBZ_FLAG_EN
        ,
        .div_by_zero(div_by_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one division and wait for done. lat is the number of edges after
    // the accepting edge at which done was first seen (BOUND on timeout);
    // busy_bad counts cycles where busy disagreed with the handshake.
    task automatic run_div(input logic s, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b,
                           output int lat, output int busy_bad);
        @(negedge clk);
        sign = s; dividend = a; divisor = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Operands changing after acceptance must not matter.
        dividend = 32'hDEAD_BEEF; divisor = 32'h0000_0005; sign = ~s;
        busy_bad = busy ? 0 : 1;
        lat = 0;
        while (lat < BOUND) begin
            @(posedge clk); #1;
            lat++;
            if (done) begin
                if (busy) busy_bad++;
                break;
            end else if (!busy) begin
                busy_bad++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sign = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00 || quotient !== '0 || remainder !== '0) begin
            n_errors++;
            $display("FAIL reset_state: busy=%b done=%b q=%h r=%h, need 0 0 0 0",
                     busy, done, quotient, remainder);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00 || quotient !== '0 || remainder !== '0) begin
            n_errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b q=%h r=%h, need 0 0 0 0",
                     busy, done, quotient, remainder);
        end
    endtask

    task automatic test_unsigned();
        logic [WIDTH-1:0] va [3] = '{32'd100, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [WIDTH-1:0] vb [3] = '{32'd7,   32'hFFFF_FFFF, 32'h0000_0010};
        logic [WIDTH-1:0] eq [3] = '{32'd14,  32'h0000_0000, 32'h0FFF_FFFF};
        logic [WIDTH-1:0] er [3] = '{32'd2,   32'h8000_0000, 32'h0000_000F};
        int lat, bb;
        for (int i = 0; i < 3; i++) begin
            run_div(1'b0, va[i], vb[i], lat, bb);
            n_checks++;
            if (lat !== LAT || bb !== 0) begin
                n_errors++;
                $display("FAIL divu_timing[%0d]: latency=%0d busy_errs=%0d, need %0d 0",
                         i, lat, bb, LAT);
            end
            n_checks++;
            if (quotient !== eq[i] || remainder !== er[i]) begin
                n_errors++;
                $display("FAIL divu_result[%0d]: q=%h r=%h, need q=%h r=%h",
                         i, quotient, remainder, eq[i], er[i]);
            end
            @(posedge clk); #1;
            n_checks++;
            if (done !== 1'b0 || quotient !== eq[i]) begin
                n_errors++;
                $display("FAIL divu_done_pulse[%0d]: done=%b q=%h, need 0 %h",
                         i, done, quotient, eq[i]);
            end
        end
    endtask

    task automatic test_signed();
        logic [WIDTH-1:0] va [4] = '{32'hFFFF_FFF9, 32'd7,       32'hFFFF_FFF9, 32'h8000_0000};
        logic [WIDTH-1:0] vb [4] = '{32'd2,       32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [WIDTH-1:0] eq [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd3,       32'h8000_0000};
        logic [WIDTH-1:0] er [4] = '{32'hFFFF_FFFF, 32'd1,       32'hFFFF_FFFF, 32'd0};
        int lat, bb;
        for (int i = 0; i < 4; i++) begin
            run_div(1'b1, va[i], vb[i], lat, bb);
            n_checks++;
            if (lat !== LAT || bb !== 0 || quotient !== eq[i] || remainder !== er[i]) begin
                n_errors++;
                $display("FAIL div_signed[%0d]: lat=%0d busy_errs=%0d q=%h r=%h, need lat=%0d q=%h r=%h",
                         i, lat, bb, quotient, remainder, LAT, eq[i], er[i]);
            end
        end
    endtask

    task automatic test_div_by_zero();
        logic [WIDTH-1:0] va [3] = '{32'h1234_5678, 32'hFFFF_FFF0, 32'd9};
        logic [WIDTH-1:0] vb [3] = '{32'd0,         32'd0,         32'd3};
        logic             vs [3] = '{1'b0,          1'b1,          1'b0};
        logic [WIDTH-1:0] eq [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3};
        logic [WIDTH-1:0] er [3] = '{32'h1234_5678, 32'hFFFF_FFF0, 32'd0};
        int lat, bb;
        for (int i = 0; i < 3; i++) begin
            run_div(vs[i], va[i], vb[i], lat, bb);
            n_checks++;
            if (lat !== LAT || bb !== 0 || quotient !== eq[i] || remainder !== er[i]) begin
                n_errors++;
                $display("FAIL div_by_zero[%0d]: lat=%0d busy_errs=%0d q=%h r=%h, need lat=%0d q=%h r=%h",
                         i, lat, bb, quotient, remainder, LAT, eq[i], er[i]);
            end
`ifdef ITER_DIVIDER_DBZ_FLAG_EN
            n_checks++;
            if (div_by_zero !== (i < 2)) begin
                n_errors++;
                $display("FAIL dbz_flag[%0d]: div_by_zero=%b, need %b", i, div_by_zero, (i < 2));
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        sign = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (lat < BOUND) begin
            @(posedge clk); #1;
            lat++;
            // Request raised here is sampled on edge 10, mid-calculation.
            if (lat == 9) begin
                sign = 1'b1; dividend = 32'd50; divisor = 32'd5; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) break;
        end
        n_checks++;
        if (lat !== LAT || quotient !== 32'd14 || remainder !== 32'd2) begin
            n_errors++;
            $display("FAIL start_while_busy: lat=%0d q=%h r=%h, need lat=%0d q=%h r=%h",
                     lat, quotient, remainder, LAT, 32'd14, 32'd2);
        end
        // Still in the done cycle: a new request is accepted on the next edge.
        sign = 1'b0; dividend = 32'd9; divisor = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1 || quotient !== 32'd14 || remainder !== 32'd2) begin
            n_errors++;
            $display("FAIL start_in_done_cycle: done=%b busy=%b q=%h r=%h, need 0 1 %h %h",
                     done, busy, quotient, remainder, 32'd14, 32'd2);
        end
        lat = 0;
        while (lat < BOUND) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
        end
        n_checks++;
        if (lat !== LAT || quotient !== 32'd3 || remainder !== 32'd0) begin
            n_errors++;
            $display("FAIL second_result: lat=%0d q=%h r=%h, need lat=%0d q=%h r=%h",
                     lat, quotient, remainder, LAT, 32'd3, 32'd0);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat, bb, n_done;
        @(negedge clk);
        sign = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done} !== 2'b00 || quotient !== '0 || remainder !== '0) begin
            n_errors++;
            $display("FAIL reset_mid_op: busy=%b done=%b q=%h r=%h, need 0 0 0 0",
                     busy, done, quotient, remainder);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) n_done++;
        end
        n_checks++;
        if (n_done !== 0) begin
            n_errors++;
            $display("FAIL no_done_after_abort: active_cycles=%0d, need 0", n_done);
        end
        run_div(1'b0, 32'd1000, 32'd3, lat, bb);
        n_checks++;
        if (lat !== LAT || bb !== 0 || quotient !== 32'd333 || remainder !== 32'd1) begin
            n_errors++;
            $display("FAIL div_after_abort: lat=%0d busy_errs=%0d q=%h r=%h, need lat=%0d q=%h r=%h",
                     lat, bb, quotient, remainder, LAT, 32'd333, 32'd1);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_by_zero();
        test_back_to_back();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
